// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the programmable sync FIFO family.
package sync_fifo_pkg;

    typedef enum logic {
        RD_STD  = 1'b0,
        RD_FWFT = 1'b1
    } rd_mode_e;

    localparam int ERR_CNT_W = 8;

    function automatic logic [ERR_CNT_W-1:0] err_cnt_inc(input logic [ERR_CNT_W-1:0] cnt);
        return (cnt == {ERR_CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer bus of sync_fifo_prog; master drives requests, slave is the FIFO.
// Error counter signals exist only when FIFO_ERR_CNT_EN is defined.
interface sync_fifo_prog_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    import sync_fifo_pkg::*;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic [ADDR_WIDTH:0]   af_thresh;
    logic [ADDR_WIDTH:0]   ae_thresh;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;
    logic                  underflow;
`ifdef FIFO_ERR_CNT_EN
    logic [ERR_CNT_W-1:0]  ovf_cnt;
    logic [ERR_CNT_W-1:0]  udf_cnt;

    modport master (
        output wr_en, wr_data, rd_en, af_thresh, ae_thresh,
        input  rd_data, rd_valid, fifo_full, fifo_empty, almost_full, almost_empty,
               level, overflow, underflow, ovf_cnt, udf_cnt
    );
    modport slave (
        input  wr_en, wr_data, rd_en, af_thresh, ae_thresh,
        output rd_data, rd_valid, fifo_full, fifo_empty, almost_full, almost_empty,
               level, overflow, underflow, ovf_cnt, udf_cnt
    );
`else
    modport master (
        output wr_en, wr_data, rd_en, af_thresh, ae_thresh,
        input  rd_data, rd_valid, fifo_full, fifo_empty, almost_full, almost_empty,
               level, overflow, underflow
    );
    modport slave (
        input  wr_en, wr_data, rd_en, af_thresh, ae_thresh,
        output rd_data, rd_valid, fifo_full, fifo_empty, almost_full, almost_empty,
               level, overflow, underflow
    );
`endif

endinterface

// File: rtl/sync_fifo_fwft_out.sv
// FWFT output register: prefetches the head word whenever it is empty or being popped.
// One cycle from memory to output; pops sustain one word per cycle.
module sync_fifo_fwft_out #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  hw_rst,
    input  logic                  soft_clr,
    input  logic                  mem_nonempty,
    input  logic [DATA_WIDTH-1:0] mem_dat,
    input  logic                  pop,
    output logic                  mem_rd,
    output logic [DATA_WIDTH-1:0] out_dat,
    output logic                  out_vld
);

    assign mem_rd = mem_nonempty && (!out_vld || pop);

    always_ff @(posedge clk or posedge hw_rst) begin
        if (hw_rst) begin
            out_dat <= '0;
            out_vld <= 1'b0;
        end else if (soft_clr) begin
            out_dat <= '0;
            out_vld <= 1'b0;
        end else if (mem_rd) begin
            out_dat <= mem_dat;
            out_vld <= 1'b1;
        end else if (pop) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock flop-array FIFO with programmable thresholds, standard or FWFT read, 1-cycle read latency.
// Rejects writes when full and reads when empty (flagged); FIFO_ERR_CNT_EN adds saturating error counters.
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 32,
    parameter int ADDR_WIDTH   = $clog2(DEPTH),
    parameter int FWFT         = 0,
    parameter int SOFT_RESET   = 1,
    parameter int STICKY_ERROR = 0
) (
    input logic             clk,
    input logic             hw_rst,
    input logic             sw_rst,
    sync_fifo_prog_if.slave bus
);

    localparam int             PW      = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]  DEPTH_W = PW'(DEPTH);
    localparam rd_mode_e       RD_MODE = (FWFT != 0) ? RD_FWFT : RD_STD;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         mem_cnt;
    logic [PW-1:0]         level;
    logic [DATA_WIDTH-1:0] head_dat;
    logic                  out_vld;
    logic                  mem_rd;
    logic                  soft_clr;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  wr_rej;
    logic                  rd_rej;
    logic                  ovf_q;
    logic                  udf_q;

    assign soft_clr = (SOFT_RESET != 0) && sw_rst;
    assign mem_cnt  = wr_ptr - rd_ptr;
    // The FWFT output register is part of the capacity, so it is counted in level.
    assign level     = mem_cnt + PW'(out_vld);
    assign fifo_full = (level == DEPTH_W);
    assign wr_acc    = bus.wr_en && !fifo_full;
    assign rd_acc    = bus.rd_en && !fifo_empty;
    assign wr_rej    = bus.wr_en && fifo_full;
    assign rd_rej    = bus.rd_en && fifo_empty;
    assign head_dat  = mem[rd_ptr[ADDR_WIDTH-1:0]];

    always_ff @(posedge clk or posedge hw_rst) begin
        if (hw_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (soft_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (mem_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !soft_clr) mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.wr_data;
    end

    generate
        if (RD_MODE == RD_FWFT) begin : g_fwft
            logic [DATA_WIDTH-1:0] out_dat;

            sync_fifo_fwft_out #(.DATA_WIDTH(DATA_WIDTH)) u_out (
                .clk          (clk),
                .hw_rst       (hw_rst),
                .soft_clr     (soft_clr),
                .mem_nonempty (mem_cnt != '0),
                .mem_dat      (head_dat),
                .pop          (rd_acc),
                .mem_rd       (mem_rd),
                .out_dat      (out_dat),
                .out_vld      (out_vld)
            );

            assign fifo_empty   = !out_vld;
            assign bus.rd_data  = out_dat;
            assign bus.rd_valid = out_vld;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_dat_q;
            logic                  rd_vld_q;

            always_ff @(posedge clk or posedge hw_rst) begin
                if (hw_rst) begin
                    rd_dat_q <= '0;
                    rd_vld_q <= 1'b0;
                end else if (soft_clr) begin
                    rd_dat_q <= '0;
                    rd_vld_q <= 1'b0;
                end else begin
                    if (rd_acc) rd_dat_q <= head_dat;
                    rd_vld_q <= rd_acc;
                end
            end

            assign out_vld      = 1'b0;
            assign mem_rd       = rd_acc;
            assign fifo_empty   = (level == '0);
            assign bus.rd_data  = rd_dat_q;
            assign bus.rd_valid = rd_vld_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge hw_rst) begin
        if (hw_rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (soft_clr) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= wr_rej || ((STICKY_ERROR != 0) && ovf_q);
            udf_q <= rd_rej || ((STICKY_ERROR != 0) && udf_q);
        end
    end

`ifdef FIFO_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] ovf_cnt_q;
    logic [ERR_CNT_W-1:0] udf_cnt_q;

    always_ff @(posedge clk or posedge hw_rst) begin
        if (hw_rst) begin
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
        end else if (soft_clr) begin
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
        end else begin
            if (wr_rej) ovf_cnt_q <= err_cnt_inc(ovf_cnt_q);
            if (rd_rej) udf_cnt_q <= err_cnt_inc(udf_cnt_q);
        end
    end

    assign bus.ovf_cnt = ovf_cnt_q;
    assign bus.udf_cnt = udf_cnt_q;
`endif

    assign bus.fifo_full    = fifo_full;
    assign bus.fifo_empty   = fifo_empty;
    assign bus.level        = level;
    assign bus.almost_full  = (bus.af_thresh != '0) && (level >= bus.af_thresh);
    assign bus.almost_empty = (level <= bus.ae_thresh);
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: standard (DEPTH 32), FWFT (DEPTH 8) and sticky-error (DEPTH 8) instances.
module tb_sync_fifo_prog;

    logic clk    = 1'b0;
    logic hw_rst = 1'b1;
    logic s_sw   = 1'b0;
    logic f_sw   = 1'b0;
    logic k_sw   = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    always #5 clk = ~clk;

    sync_fifo_prog_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) s_if ();
    sync_fifo_prog_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) f_if ();
    sync_fifo_prog_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) k_if ();

    sync_fifo_prog #(.DATA_WIDTH(32), .DEPTH(32), .ADDR_WIDTH(5), .FWFT(0), .SOFT_RESET(1), .STICKY_ERROR(0))
        u_s (.clk(clk), .hw_rst(hw_rst), .sw_rst(s_sw), .bus(s_if));
    sync_fifo_prog #(.DATA_WIDTH(32), .DEPTH(8), .ADDR_WIDTH(3), .FWFT(1), .SOFT_RESET(1), .STICKY_ERROR(0))
        u_f (.clk(clk), .hw_rst(hw_rst), .sw_rst(f_sw), .bus(f_if));
    sync_fifo_prog #(.DATA_WIDTH(32), .DEPTH(8), .ADDR_WIDTH(3), .FWFT(0), .SOFT_RESET(1), .STICKY_ERROR(1))
        u_k (.clk(clk), .hw_rst(hw_rst), .sw_rst(k_sw), .bus(k_if));

    logic [31:0] s_q [$];
    logic [31:0] f_q [$];
    logic [31:0] k_q [$];
    logic [31:0] s_wd = 32'd0;
    logic [31:0] s_exp;
    int          s_lvl = 0;

    // Standard-mode scoreboard: every rd_valid pulse must match the oldest accepted write.
    always @(negedge clk) begin
        if (!hw_rst && s_if.rd_valid) begin
            total++;
            if (s_q.size() == 0) begin
                bad++;
                $display("FAIL std_rd_spurious: got rd_data %0h, required no rd_valid", s_if.rd_data);
            end else begin
                s_exp = s_q.pop_front();
                if (s_if.rd_data !== s_exp) begin
                    bad++;
                    $display("FAIL std_rd_data: got %0h, required %0h", s_if.rd_data, s_exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic s_cycle(input bit wr, input bit rd);
        bit wa, ra;
        ra = rd && (s_lvl != 0);
        wa = wr && (s_lvl != 32);
        s_if.wr_en   = wr;
        s_if.rd_en   = rd;
        s_if.wr_data = s_wd;
        if (wa) s_q.push_back(s_wd);
        step();
        if (wa) s_wd = s_wd + 1;
        s_lvl = s_lvl + int'(wa) - int'(ra);
        s_if.wr_en = 1'b0;
        s_if.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) step();
        total++;
        if ({s_if.fifo_empty, s_if.fifo_full, s_if.almost_empty, s_if.rd_valid, s_if.overflow, s_if.underflow} !== 6'b101000) begin
            bad++;
            $display("FAIL reset_std_flags: got %b, required 101000",
                     {s_if.fifo_empty, s_if.fifo_full, s_if.almost_empty, s_if.rd_valid, s_if.overflow, s_if.underflow});
        end
        total++;
        if (s_if.level !== 6'd0 || s_if.rd_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_std_level_data: got level %0d data %0h, required 0 0", s_if.level, s_if.rd_data);
        end
        total++;
        if ({f_if.fifo_empty, f_if.rd_valid, k_if.fifo_empty, k_if.underflow} !== 4'b1010) begin
            bad++;
            $display("FAIL reset_fwft_sticky: got %b, required 1010",
                     {f_if.fifo_empty, f_if.rd_valid, k_if.fifo_empty, k_if.underflow});
        end
        @(negedge clk);
        hw_rst = 1'b0;
        step();
    endtask

    task automatic test_fill_thresholds();
        for (int i = 0; i < 32; i++) begin
            s_cycle(1'b1, 1'b0);
            if (s_lvl == 27 || s_lvl == 28) begin
                total++;
                if (s_if.almost_full !== (s_lvl == 28)) begin
                    bad++;
                    $display("FAIL almost_full_at_%0d: got %b, required %b", s_lvl, s_if.almost_full, s_lvl == 28);
                end
            end
        end
        total++;
        if (s_if.fifo_full !== 1'b1 || s_if.level !== 6'd32) begin
            bad++;
            $display("FAIL std_full: got full %b level %0d, required 1 32", s_if.fifo_full, s_if.level);
        end
        s_cycle(1'b1, 1'b0);
        total++;
        if (s_if.overflow !== 1'b1 || s_if.level !== 6'd32) begin
            bad++;
            $display("FAIL std_overflow: got ovf %b level %0d, required 1 32", s_if.overflow, s_if.level);
        end
        s_cycle(1'b0, 1'b0);
        total++;
        if (s_if.overflow !== 1'b0) begin
            bad++;
            $display("FAIL std_overflow_pulse: got %b, required 0", s_if.overflow);
        end
        for (int i = 0; i < 32; i++) begin
            s_cycle(1'b0, 1'b1);
            if (s_lvl == 3 || s_lvl == 4) begin
                total++;
                if (s_if.almost_empty !== (s_lvl == 3)) begin
                    bad++;
                    $display("FAIL almost_empty_at_%0d: got %b, required %b", s_lvl, s_if.almost_empty, s_lvl == 3);
                end
            end
        end
        s_cycle(1'b0, 1'b0);
        total++;
        if (s_if.fifo_empty !== 1'b1 || s_if.level !== 6'd0 || s_q.size() != 0) begin
            bad++;
            $display("FAIL std_drain: got empty %b level %0d unread %0d, required 1 0 0",
                     s_if.fifo_empty, s_if.level, s_q.size());
        end
    endtask

    task automatic test_simultaneous();
        repeat (16) s_cycle(1'b1, 1'b0);
        s_cycle(1'b1, 1'b1);
        total++;
        if (s_if.level !== 6'd16) begin
            bad++;
            $display("FAIL simul_mid_level: got %0d, required 16", s_if.level);
        end
        repeat (16) s_cycle(1'b1, 1'b0);
        s_cycle(1'b1, 1'b1);
        total++;
        if (s_if.overflow !== 1'b1 || s_if.level !== 6'd31) begin
            bad++;
            $display("FAIL simul_full: got ovf %b level %0d, required 1 31", s_if.overflow, s_if.level);
        end
        while (s_lvl > 0) s_cycle(1'b0, 1'b1);
        s_cycle(1'b1, 1'b1);
        total++;
        if (s_if.underflow !== 1'b1 || s_if.level !== 6'd1) begin
            bad++;
            $display("FAIL simul_empty: got udf %b level %0d, required 1 1", s_if.underflow, s_if.level);
        end
        s_cycle(1'b0, 1'b1);
        s_cycle(1'b0, 1'b0);
        total++;
        if (s_q.size() != 0 || s_if.level !== 6'd0) begin
            bad++;
            $display("FAIL simul_drain: got unread %0d level %0d, required 0 0", s_q.size(), s_if.level);
        end
    endtask

    task automatic test_fwft_first_word();
        f_if.wr_data = 32'hA5;
        f_if.wr_en   = 1'b1;
        step();
        f_if.wr_en = 1'b0;
        total++;
        if (f_if.rd_valid !== 1'b0 || f_if.level !== 4'd1) begin
            bad++;
            $display("FAIL fwft_edge_n: got valid %b level %0d, required 0 1", f_if.rd_valid, f_if.level);
        end
        step();
        total++;
        if (f_if.rd_valid !== 1'b1 || f_if.rd_data !== 32'hA5 || f_if.fifo_empty !== 1'b0) begin
            bad++;
            $display("FAIL fwft_edge_n1: got valid %b data %0h empty %b, required 1 a5 0",
                     f_if.rd_valid, f_if.rd_data, f_if.fifo_empty);
        end
        f_if.rd_en = 1'b1;
        step();
        f_if.rd_en = 1'b0;
        total++;
        if (f_if.rd_valid !== 1'b0 || f_if.fifo_empty !== 1'b1 || f_if.level !== 4'd0) begin
            bad++;
            $display("FAIL fwft_pop: got valid %b empty %b level %0d, required 0 1 0",
                     f_if.rd_valid, f_if.fifo_empty, f_if.level);
        end
    endtask

    task automatic test_fwft_back_to_back();
        logic [31:0] e;
        for (int i = 0; i < 8; i++) begin
            f_if.wr_data = 32'hB0 + i;
            f_if.wr_en   = 1'b1;
            f_q.push_back(32'hB0 + i);
            step();
        end
        f_if.wr_en = 1'b0;
        step();
        total++;
        if (f_if.fifo_full !== 1'b1 || f_if.level !== 4'd8 || f_if.almost_full !== 1'b0) begin
            bad++;
            $display("FAIL fwft_full: got full %b level %0d af %b, required 1 8 0",
                     f_if.fifo_full, f_if.level, f_if.almost_full);
        end
        f_if.rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e = f_q.pop_front();
            total++;
            if (f_if.rd_valid !== 1'b1 || f_if.rd_data !== e) begin
                bad++;
                $display("FAIL fwft_b2b_%0d: got valid %b data %0h, required 1 %0h", i, f_if.rd_valid, f_if.rd_data, e);
            end
            step();
        end
        f_if.rd_en = 1'b0;
        total++;
        if (f_if.rd_valid !== 1'b0 || f_if.fifo_empty !== 1'b1) begin
            bad++;
            $display("FAIL fwft_b2b_end: got valid %b empty %b, required 0 1", f_if.rd_valid, f_if.fifo_empty);
        end
    endtask

    task automatic test_sticky();
        bit          held = 1'b1;
        logic [31:0] e;
        k_if.rd_en = 1'b1;
        step();
        k_if.rd_en = 1'b0;
        repeat (100) begin
            step();
            if (k_if.underflow !== 1'b1) held = 1'b0;
        end
        total++;
        if (held !== 1'b1) begin
            bad++;
            $display("FAIL sticky_hold: got dropped %b, required held 1", held);
        end
        for (int i = 0; i < 3; i++) begin
            k_if.wr_data = 32'hD0 + i;
            k_if.wr_en   = 1'b1;
            step();
        end
        k_if.wr_en = 1'b0;
        k_sw = 1'b1;
        step();
        k_sw = 1'b0;
        total++;
        if (k_if.underflow !== 1'b0 || k_if.level !== 4'd0 || k_if.fifo_empty !== 1'b1) begin
            bad++;
            $display("FAIL sticky_swrst: got udf %b level %0d empty %b, required 0 0 1",
                     k_if.underflow, k_if.level, k_if.fifo_empty);
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) begin
                k_if.wr_data = 32'hC0 + 16 * r + i;
                k_if.wr_en   = 1'b1;
                k_q.push_back(32'hC0 + 16 * r + i);
                step();
            end
            k_if.wr_en = 1'b0;
            total++;
            if (k_if.fifo_full !== 1'b1 || k_if.almost_full !== 1'b1) begin
                bad++;
                $display("FAIL sticky_refill_%0d: got full %b af %b, required 1 1", r, k_if.fifo_full, k_if.almost_full);
            end
            for (int i = 0; i < 8; i++) begin
                k_if.rd_en = 1'b1;
                step();
                e = k_q.pop_front();
                total++;
                if (k_if.rd_valid !== 1'b1 || k_if.rd_data !== e) begin
                    bad++;
                    $display("FAIL sticky_read_%0d_%0d: got valid %b data %0h, required 1 %0h",
                             r, i, k_if.rd_valid, k_if.rd_data, e);
                end
            end
            k_if.rd_en = 1'b0;
        end
    endtask

    task automatic test_err_cnt_hw_rst();
        repeat (5) s_cycle(1'b1, 1'b0);
        for (int i = 0; i < 308; i++) begin
            k_if.wr_data = i;
            k_if.wr_en   = 1'b1;
            step();
        end
`ifdef FIFO_ERR_CNT_EN
        total++;
        if (k_if.ovf_cnt !== 8'd255 || k_if.udf_cnt !== 8'd0) begin
            bad++;
            $display("FAIL err_cnt_sat: got ovf_cnt %0d udf_cnt %0d, required 255 0", k_if.ovf_cnt, k_if.udf_cnt);
        end
`endif
        total++;
        if (k_if.overflow !== 1'b1 || k_if.fifo_full !== 1'b1) begin
            bad++;
            $display("FAIL burst_ovf: got ovf %b full %b, required 1 1", k_if.overflow, k_if.fifo_full);
        end
        #2 hw_rst = 1'b1;
        #1;
        total++;
        if ({k_if.fifo_empty, k_if.fifo_full, k_if.almost_empty, k_if.rd_valid, k_if.overflow, k_if.underflow} !== 6'b101000) begin
            bad++;
            $display("FAIL hwrst_flags: got %b, required 101000",
                     {k_if.fifo_empty, k_if.fifo_full, k_if.almost_empty, k_if.rd_valid, k_if.overflow, k_if.underflow});
        end
        total++;
        if (k_if.level !== 4'd0 || k_if.rd_data !== 32'd0 || s_if.level !== 6'd0) begin
            bad++;
            $display("FAIL hwrst_level: got k %0d data %0h s %0d, required 0 0 0", k_if.level, k_if.rd_data, s_if.level);
        end
`ifdef FIFO_ERR_CNT_EN
        total++;
        if (k_if.ovf_cnt !== 8'd0) begin
            bad++;
            $display("FAIL hwrst_cnt: got %0d, required 0", k_if.ovf_cnt);
        end
`endif
        k_if.wr_en = 1'b0;
        s_q.delete();
        k_q.delete();
        s_lvl = 0;
        @(negedge clk);
        hw_rst = 1'b0;
        s_cycle(1'b1, 1'b0);
        s_cycle(1'b0, 1'b1);
        s_cycle(1'b0, 1'b0);
        total++;
        if (s_q.size() != 0 || s_if.fifo_empty !== 1'b1) begin
            bad++;
            $display("FAIL post_rst_rw: got unread %0d empty %b, required 0 1", s_q.size(), s_if.fifo_empty);
        end
    endtask

    initial begin
        s_if.wr_en = 1'b0; s_if.rd_en = 1'b0; s_if.wr_data = '0;
        s_if.af_thresh = 6'd28; s_if.ae_thresh = 6'd3;
        f_if.wr_en = 1'b0; f_if.rd_en = 1'b0; f_if.wr_data = '0;
        f_if.af_thresh = 4'd0; f_if.ae_thresh = 4'd2;
        k_if.wr_en = 1'b0; k_if.rd_en = 1'b0; k_if.wr_data = '0;
        k_if.af_thresh = 4'd6; k_if.ae_thresh = 4'd1;
        test_reset();
        test_fill_thresholds();
        test_simultaneous();
        test_fwft_first_word();
        test_fwft_back_to_back();
        test_sticky();
        test_err_cnt_hw_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
